mailbox_ctrl: RTL and testbench
===============================

# mailbox_ctrl

Sequencing controller for the fabric mailbox memory.
- Shares one mailbox memory between NUM_REQ message producers using round-robin arbitration.
- Streams the granted producer's MESSAGE_DEPTH words into the memory, then raises an interrupt to the single consumer.
- Passes consumer reads through to the memory until the consumer acknowledges, then frees the mailbox for the next producer.
- Sits between fabric producer logic and the mailbox memory; the memory keeps its write/read-select interface unchanged.

## Interface
- NUM_REQ, 2: number of producers, 2..8.
- MESSAGE_DEPTH, 4: words per message, 1..8; must equal the attached memory's MESSAGE_DEPTH.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer word valid; a producer requests the mailbox by asserting it.
- req_data  in  NUM_REQ*32  per-producer word; producer i uses bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  per-producer word accepted; only the owner's bit can be 1.
- mem_wr  out  1  memory write strobe.
- mem_wr_sel  out  3  memory write word index.
- mem_wdata  out  32  memory write data.
- mem_wr_ready  in  1  memory accepts a write this cycle.
- mem_rd  out  1  memory read strobe.
- mem_rd_sel  out  3  memory read word index.
- mem_rdata  in  32  memory read data; combinational from mem_rd/mem_rd_sel.
- mem_rvalid  in  1  memory read data valid.
- cons_rd  in  1  consumer read request.
- cons_rd_sel  in  3  consumer word index.
- cons_rdata  out  32  consumer read data.
- cons_rvalid  out  1  consumer read data valid.
- cons_ack  in  1  consumer releases the message; single-cycle pulse.
- msg_irq  out  1  message posted; level signal.
- msg_src  out  3  producer index of the posted message.

## Operation
FSM states: IDLE, WRITE, POSTED.

- **IDLE**
  - If any req_valid bit is set, the round-robin arbiter picks the first requester after last_owner (wrapping at NUM_REQ-1).
  - The winner is latched into owner, cnt is cleared, and the FSM moves to WRITE.
  - No req_ready is asserted while in IDLE.
- **WRITE**
  - req_ready[owner] = mem_wr_ready.
  - mem_wr = req_valid[owner] & mem_wr_ready.
  - mem_wr_sel = cnt; mem_wdata = owner's req_data slice.
  - Each accepted beat increments cnt.
  - The beat accepted with cnt == MESSAGE_DEPTH-1 moves the FSM to POSTED.
  - If the owner drops req_valid, the FSM holds in WRITE and cnt is kept; there is no timeout.
  - Other producers' req_valid are ignored and their req_ready stays 0.
- **POSTED**
  - msg_irq = 1; msg_src = owner.
  - Reads pass through: mem_rd = cons_rd, mem_rd_sel = cons_rd_sel, cons_rdata = mem_rdata, cons_rvalid = mem_rvalid.
  - cons_ack moves the FSM to IDLE and sets last_owner = owner.
- **Outside POSTED**
  - mem_rd = 0, cons_rvalid = 0, cons_rdata = 0.
  - cons_ack is ignored.
- cons_rd_sel >= MESSAGE_DEPTH is forwarded unchanged; the memory returns rvalid = 0 and the controller adds no check.
- cnt and all selects are 3 bits; MESSAGE_DEPTH-1 <= 7, so cnt never wraps within a message.

## Timing
- Reset values:
  - state = IDLE, owner = 0, last_owner = NUM_REQ-1 (producer 0 has first priority), cnt = 0.
  - All outputs 0: req_ready, mem_wr, mem_wr_sel, mem_wdata, mem_rd, mem_rd_sel, cons_rdata, cons_rvalid, msg_irq, msg_src.
- Grant latency: req_valid seen in IDLE at cycle k → WRITE at k+1 → first word can be accepted at k+1.
- Message latency: a full message with no stalls takes MESSAGE_DEPTH cycles in WRITE; msg_irq rises the cycle after the last beat is accepted.
- Consumer reads are combinational in POSTED: cons_rdata and cons_rvalid follow cons_rd in the same cycle.
- Release: cons_ack at cycle a → IDLE at a+1 with msg_irq = 0 → next grant at a+2 at the earliest (one-cycle bubble by design).
- cons_ack and cons_rd in the same POSTED cycle: the read completes, then the FSM releases.
- Reset asserted mid-WRITE or mid-POSTED:
  - Aborts the message at the next clock edge and returns all state to reset values.
  - Memory contents are not cleared; msg_irq drops.

## Structure
- Package mailbox_pkg holds:
  - the state enum (IDLE, WRITE, POSTED);
  - SEL_W = 3 and MAX_DEPTH = 8;
  - MAX_REQ = 8, which sizes the 3-bit owner and msg_src.
- Sub-module rr_arbiter (NUM_REQ): combinational inputs req and last_owner; outputs a one-hot grant and its index.

## Test plan
- **Single producer, no stalls.** Reset, then req_valid = 01 with words 0x11, 0x22, 0x33, 0x44 (MESSAGE_DEPTH = 4).
  - Expect mem_wr on four consecutive cycles with sel 0..3.
  - Expect msg_irq = 1 and msg_src = 0 the following cycle.
  - Consumer reads sel 2 → cons_rdata = 0x33, cons_rvalid = 1.
- **Simultaneous requests.** req_valid = 11 after reset.
  - Producer 0 is served first; after cons_ack, producer 1 is granted two cycles later with msg_src = 1.
  - A third round with both still requesting grants producer 0.
- **Backpressure and gaps.**
  - mem_wr_ready = 0 for 3 cycles mid-message → req_ready[owner] = 0 and cnt holds.
  - Owner drops req_valid for 2 cycles → no mem_wr.
  - Message still completes with sel 0..3 in order and the correct data.
- **Blocked accesses.**
  - cons_rd while in WRITE → mem_rd = 0, cons_rvalid = 0.
  - cons_ack while in WRITE → ignored; the message still posts.
  - Producer 1 req_valid while producer 0 owns → req_ready[1] = 0.
- **Reset mid-operation.**
  - reset after 2 of 4 beats → next cycle IDLE, all outputs 0, no msg_irq.
  - A new request from producer 1 alone is granted from sel 0.
- **Read/ack coincidence.** cons_rd (sel 3) and cons_ack in the same POSTED cycle → cons_rdata = word 3 that cycle, msg_irq = 0 the next cycle.

Source files
------------

// File: rtl/mailbox_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mailbox_pkg : shared types and sizing for the mailbox controller     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package mailbox_pkg;

    localparam int SEL_W     = 3;
    localparam int MAX_DEPTH = 8;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        POSTED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mailbox_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mailbox_ctrl_if : producer, memory and consumer signals of the box   |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
interface mailbox_ctrl_if
    import mailbox_pkg::*;
#(
    parameter int NUM_REQ = 2
) ();

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mem_wr;
    logic [SEL_W-1:0]      mem_wr_sel;
    logic [31:0]           mem_wdata;
    logic                  mem_wr_ready;
    logic                  mem_rd;
    logic [SEL_W-1:0]      mem_rd_sel;
    logic [31:0]           mem_rdata;
    logic                  mem_rvalid;
    logic                  cons_rd;
    logic [SEL_W-1:0]      cons_rd_sel;
    logic [31:0]           cons_rdata;
    logic                  cons_rvalid;
    logic                  cons_ack;
    logic                  msg_irq;
    logic [SEL_W-1:0]      msg_src;

    // Controller side.
    modport slave (
        input  req_valid, req_data, mem_wr_ready, mem_rdata, mem_rvalid,
               cons_rd, cons_rd_sel, cons_ack,
        output req_ready, mem_wr, mem_wr_sel, mem_wdata, mem_rd, mem_rd_sel,
               cons_rdata, cons_rvalid, msg_irq, msg_src
    );

    // Environment side: producers, memory and consumer.
    modport master (
        output req_valid, req_data, mem_wr_ready, mem_rdata, mem_rvalid,
               cons_rd, cons_rd_sel, cons_ack,
        input  req_ready, mem_wr, mem_wr_sel, mem_wdata, mem_rd, mem_rd_sel,
               cons_rdata, cons_rvalid, msg_irq, msg_src
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick after last_owner         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module rr_arbiter
    import mailbox_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   grant_idx
);

    int w_best;
    int w_dist;

    // Distance 0 is the producer right after last_owner; smallest distance wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                w_dist = (i + NUM_REQ - 1 - int'(last_owner)) % NUM_REQ;
                if (w_dist < w_best) begin
                    w_best    = w_dist;
                    grant_idx = SEL_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = (w_best < NUM_REQ) && (grant_idx == SEL_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mailbox_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mailbox_ctrl : arbitrates producers into the mailbox memory, posts   |
// |                an interrupt and passes consumer reads until ack      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module mailbox_ctrl
    import mailbox_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int MESSAGE_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    mailbox_ctrl_if.slave  bus
);

    localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(MESSAGE_DEPTH - 1);
    localparam logic [SEL_W-1:0] c_last_req = SEL_W'(NUM_REQ - 1);

    state_t           r_state_q,      w_state_d;
    logic [SEL_W-1:0] r_owner_q,      w_owner_d;
    logic [SEL_W-1:0] r_last_owner_q, w_last_owner_d;
    logic [SEL_W-1:0] r_cnt_q,        w_cnt_d;

    logic [NUM_REQ-1:0] w_grant;
    logic [SEL_W-1:0]   w_grant_idx;
    logic [MAX_REQ-1:0] w_valid_ext;
    logic [31:0]        w_words [MAX_REQ];
    logic               w_owner_valid;
    logic [31:0]        w_owner_word;
    logic               w_beat;

    // Pad the per-producer lanes to MAX_REQ so the 3-bit owner indexes them exactly.
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_lane
        if (gi < NUM_REQ) begin : g_used
            assign w_valid_ext[gi] = bus.req_valid[gi];
            assign w_words[gi]     = bus.req_data[32*gi +: 32];
        end else begin : g_unused
            assign w_valid_ext[gi] = 1'b0;
            assign w_words[gi]     = '0;
        end
    end

    assign w_owner_valid = w_valid_ext[r_owner_q];
    assign w_owner_word  = w_words[r_owner_q];
    assign w_beat        = (r_state_q == WRITE) && w_owner_valid && bus.mem_wr_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (bus.req_valid),
        .last_owner (r_last_owner_q),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= IDLE;
            r_owner_q      <= '0;
            r_last_owner_q <= c_last_req;
            r_cnt_q        <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_owner_q      <= w_owner_d;
            r_last_owner_q <= w_last_owner_d;
            r_cnt_q        <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_owner_d       = r_owner_q;
        w_last_owner_d  = r_last_owner_q;
        w_cnt_d         = r_cnt_q;
        bus.req_ready   = '0;
        bus.mem_wr      = 1'b0;
        bus.mem_wr_sel  = '0;
        bus.mem_wdata   = '0;
        bus.mem_rd      = 1'b0;
        bus.mem_rd_sel  = '0;
        bus.cons_rdata  = '0;
        bus.cons_rvalid = 1'b0;
        bus.msg_irq     = 1'b0;
        bus.msg_src     = '0;

        case (r_state_q)
            IDLE: begin
                if (|w_grant) begin
                    w_owner_d = w_grant_idx;
                    w_cnt_d   = '0;
                    w_state_d = WRITE;
                end
            end

            WRITE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.req_ready[i] = (r_owner_q == SEL_W'(i)) && bus.mem_wr_ready;
                end
                bus.mem_wr     = w_beat;
                bus.mem_wr_sel = r_cnt_q;
                bus.mem_wdata  = w_owner_word;
                if (w_beat) begin
                    w_cnt_d = r_cnt_q + SEL_W'(1);
                    if (r_cnt_q == c_last_sel) begin
                        w_state_d = POSTED;
                    end
                end
            end

            POSTED: begin
                bus.msg_irq     = 1'b1;
                bus.msg_src     = r_owner_q;
                bus.mem_rd      = bus.cons_rd;
                bus.mem_rd_sel  = bus.cons_rd_sel;
                bus.cons_rdata  = bus.mem_rdata;
                bus.cons_rvalid = bus.mem_rvalid;
                // A read in the ack cycle still completes; release takes effect next cycle.
                if (bus.cons_ack) begin
                    w_last_owner_d = r_owner_q;
                    w_state_d      = IDLE;
                end
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mailbox_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mailbox_ctrl : randomized self-checking bench for mailbox_ctrl    |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_mailbox_ctrl;

    localparam int N     = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mailbox_ctrl_if #(.NUM_REQ(N)) bus ();

    mailbox_ctrl #(
        .NUM_REQ       (N),
        .MESSAGE_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural mailbox memory.
    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (bus.mem_wr && bus.mem_wr_ready) mem[bus.mem_wr_sel] <= bus.mem_wdata;
    end
    assign bus.mem_rvalid = bus.mem_rd && (bus.mem_rd_sel < 3'(DEPTH));
    assign bus.mem_rdata  = (bus.mem_rd && (bus.mem_rd_sel < 3'(DEPTH))) ? mem[bus.mem_rd_sel] : 32'h0;

    // Producer model: each producer streams pw[i][*] while active and not gapped.
    logic [31:0]  pw [N][DEPTH];
    int           pidx [N];
    logic [N-1:0] pact;
    logic [N-1:0] pgap;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [78:0] outs_vec();
        return {bus.req_ready, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata, bus.mem_rd,
                bus.mem_rd_sel, bus.cons_rdata, bus.cons_rvalid, bus.msg_irq, bus.msg_src};
    endfunction

    task automatic drive_prod();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = pact[i] && !pgap[i] && (pidx[i] < DEPTH);
            if (pidx[i] < DEPTH) bus.req_data[32*i +: 32] = pw[i][pidx[i]];
            else                 bus.req_data[32*i +: 32] = 32'h0;
        end
    endtask

    task automatic load_prod(input int i);
        for (int b = 0; b < DEPTH; b++) pw[i][b] = $urandom;
        pidx[i] = 0;
        pact[i] = 1'b1;
    endtask

    // Ends 2 time units after the next rising edge with producer inputs updated.
    task automatic clk_step();
        logic [N-1:0] fired;
        #1;
        fired = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fired[i]) pidx[i]++;
        drive_prod();
        #1;
    endtask

    task automatic run_to_irq(output int cyc);
        cyc = 0;
        while (!bus.msg_irq && cyc < 40) begin
            clk_step();
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pact = '0; pgap = '0;
        for (int i = 0; i < N; i++) pidx[i] = 0;
        bus.cons_rd = 1'b0; bus.cons_rd_sel = '0; bus.cons_ack = 1'b0;
        bus.mem_wr_ready = 1'b1;
        drive_prod();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic ack_release();
        bus.cons_rd = 1'b0;
        bus.cons_ack = 1'b1;
        clk_step();
        bus.cons_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_prod(0); load_prod(1);
        bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'd1;
        drive_prod();
        @(posedge clk); @(posedge clk); #2;
        n_checks++;
        if (outs_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", outs_vec());
        else n_pass++;
        bus.cons_rd = 1'b0;
        reset = 1'b0;
        clk_step();
        n_checks++;
        if (bus.req_ready !== 2'b01) $display("FAIL reset_first_priority: got %b want 01", bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        pw[0][0] = 32'h11; pw[0][1] = 32'h22; pw[0][2] = 32'h33; pw[0][3] = 32'h44;
        pidx[0] = 0; pact = 2'b01;
        drive_prod(); #1;
        n_checks++;
        if ({bus.req_ready, bus.mem_wr} !== 3'b000) $display("FAIL single_idle: got %b want 000", {bus.req_ready, bus.mem_wr});
        else n_pass++;
        for (int b = 0; b < DEPTH; b++) begin
            clk_step();
            n_checks++;
            if ({bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata, bus.req_ready, bus.msg_irq} !== {1'b1, 3'(b), pw[0][b], 2'b01, 1'b0})
                $display("FAIL single_beat%0d: got wr=%b sel=%0d data=%h rdy=%b irq=%b want wr=1 sel=%0d data=%h rdy=01 irq=0",
                         b, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata, bus.req_ready, bus.msg_irq, b, pw[0][b]);
            else n_pass++;
        end
        clk_step();
        n_checks++;
        if ({bus.msg_irq, bus.msg_src, bus.mem_wr} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL single_posted: got irq=%b src=%0d wr=%b want irq=1 src=0 wr=0", bus.msg_irq, bus.msg_src, bus.mem_wr);
        else n_pass++;
        bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'd2; #1;
        n_checks++;
        if ({bus.cons_rvalid, bus.cons_rdata} !== {1'b1, 32'h33})
            $display("FAIL single_read: got v=%b data=%h want v=1 data=33", bus.cons_rvalid, bus.cons_rdata);
        else n_pass++;
        ack_release();
        n_checks++;
        if (bus.msg_irq !== 1'b0) $display("FAIL single_release: got irq=%b want 0", bus.msg_irq);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int cyc;
        do_reset();
        load_prod(0); load_prod(1);
        drive_prod();
        run_to_irq(cyc);
        n_checks++;
        if ({bus.msg_irq, bus.msg_src, 8'(cyc)} !== {1'b1, 3'd0, 8'(DEPTH + 1)})
            $display("FAIL simul_round1: got irq=%b src=%0d cycles=%0d want irq=1 src=0 cycles=%0d", bus.msg_irq, bus.msg_src, cyc, DEPTH + 1);
        else n_pass++;
        for (int b = 0; b < DEPTH; b++) begin
            bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'(b); #1;
            n_checks++;
            if ({bus.cons_rvalid, bus.cons_rdata} !== {1'b1, pw[0][b]})
                $display("FAIL simul_read%0d: got v=%b data=%h want v=1 data=%h", b, bus.cons_rvalid, bus.cons_rdata, pw[0][b]);
            else n_pass++;
        end
        ack_release();
        n_checks++;
        if ({bus.msg_irq, bus.req_ready, bus.mem_wr} !== 4'b0000)
            $display("FAIL simul_bubble: got irq=%b rdy=%b wr=%b want all 0", bus.msg_irq, bus.req_ready, bus.mem_wr);
        else n_pass++;
        clk_step();
        n_checks++;
        if ({bus.req_ready, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata} !== {2'b10, 1'b1, 3'd0, pw[1][0]})
            $display("FAIL simul_grant1: got rdy=%b wr=%b sel=%0d data=%h want rdy=10 wr=1 sel=0 data=%h",
                     bus.req_ready, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata, pw[1][0]);
        else n_pass++;
        run_to_irq(cyc);
        n_checks++;
        if ({bus.msg_irq, bus.msg_src} !== {1'b1, 3'd1})
            $display("FAIL simul_round2: got irq=%b src=%0d want irq=1 src=1", bus.msg_irq, bus.msg_src);
        else n_pass++;
        ack_release();
        load_prod(0); load_prod(1);
        drive_prod();
        clk_step();
        n_checks++;
        if ({bus.req_ready, bus.mem_wdata} !== {2'b01, pw[0][0]})
            $display("FAIL simul_round3: got rdy=%b data=%h want rdy=01 data=%h", bus.req_ready, bus.mem_wdata, pw[0][0]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        load_prod(0);
        drive_prod();
        clk_step(); clk_step(); clk_step();
        bus.mem_wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({bus.req_ready, bus.mem_wr, bus.mem_wr_sel} !== {2'b00, 1'b0, 3'd2})
                $display("FAIL bp_stall%0d: got rdy=%b wr=%b sel=%0d want rdy=00 wr=0 sel=2", k, bus.req_ready, bus.mem_wr, bus.mem_wr_sel);
            else n_pass++;
            clk_step();
        end
        bus.mem_wr_ready = 1'b1;
        pgap[0] = 1'b1;
        drive_prod();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({bus.req_ready, bus.mem_wr, bus.mem_wr_sel} !== {2'b01, 1'b0, 3'd2})
                $display("FAIL bp_gap%0d: got rdy=%b wr=%b sel=%0d want rdy=01 wr=0 sel=2", k, bus.req_ready, bus.mem_wr, bus.mem_wr_sel);
            else n_pass++;
            clk_step();
        end
        pgap[0] = 1'b0;
        drive_prod();
        for (int b = 2; b < DEPTH; b++) begin
            #1;
            n_checks++;
            if ({bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata} !== {1'b1, 3'(b), pw[0][b]})
                $display("FAIL bp_resume%0d: got wr=%b sel=%0d data=%h want wr=1 sel=%0d data=%h",
                         b, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata, b, pw[0][b]);
            else n_pass++;
            clk_step();
        end
        for (int b = 0; b < DEPTH; b++) begin
            bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'(b); #1;
            n_checks++;
            if ({bus.msg_irq, bus.cons_rvalid, bus.cons_rdata} !== {1'b1, 1'b1, pw[0][b]})
                $display("FAIL bp_read%0d: got irq=%b v=%b data=%h want irq=1 v=1 data=%h", b, bus.msg_irq, bus.cons_rvalid, bus.cons_rdata, pw[0][b]);
            else n_pass++;
        end
        ack_release();
    endtask

    task automatic test_blocked();
        int cyc;
        do_reset();
        load_prod(0);
        drive_prod();
        clk_step();
        load_prod(1);
        bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'd1; bus.cons_ack = 1'b1;
        drive_prod(); #1;
        n_checks++;
        if ({bus.mem_rd, bus.cons_rvalid, bus.cons_rdata} !== 34'h0)
            $display("FAIL blocked_read: got rd=%b v=%b data=%h want 0", bus.mem_rd, bus.cons_rvalid, bus.cons_rdata);
        else n_pass++;
        n_checks++;
        if (bus.req_ready !== 2'b01) $display("FAIL blocked_other_ready: got %b want 01", bus.req_ready);
        else n_pass++;
        run_to_irq(cyc);
        bus.cons_ack = 1'b0; bus.cons_rd = 1'b0; #1;
        n_checks++;
        if ({bus.msg_irq, bus.msg_src} !== {1'b1, 3'd0})
            $display("FAIL blocked_ack_ignored: got irq=%b src=%0d want irq=1 src=0", bus.msg_irq, bus.msg_src);
        else n_pass++;
        ack_release();
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        load_prod(0);
        drive_prod();
        clk_step(); clk_step(); clk_step();
        reset = 1'b1;
        pact = '0;
        drive_prod();
        clk_step();
        n_checks++;
        if (outs_vec() !== '0) $display("FAIL midreset_outputs: got %h want 0", outs_vec());
        else n_pass++;
        reset = 1'b0;
        clk_step();
        n_checks++;
        if (bus.msg_irq !== 1'b0) $display("FAIL midreset_irq: got %b want 0", bus.msg_irq);
        else n_pass++;
        load_prod(1);
        drive_prod();
        clk_step();
        n_checks++;
        if ({bus.req_ready, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata} !== {2'b10, 1'b1, 3'd0, pw[1][0]})
            $display("FAIL midreset_regrant: got rdy=%b wr=%b sel=%0d data=%h want rdy=10 wr=1 sel=0 data=%h",
                     bus.req_ready, bus.mem_wr, bus.mem_wr_sel, bus.mem_wdata, pw[1][0]);
        else n_pass++;
        run_to_irq(cyc);
        n_checks++;
        if ({bus.msg_irq, bus.msg_src} !== {1'b1, 3'd1})
            $display("FAIL midreset_post: got irq=%b src=%0d want irq=1 src=1", bus.msg_irq, bus.msg_src);
        else n_pass++;
        ack_release();
    endtask

    task automatic test_read_ack();
        int cyc;
        do_reset();
        load_prod(0);
        drive_prod();
        run_to_irq(cyc);
        bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'd3; bus.cons_ack = 1'b1; #1;
        n_checks++;
        if ({bus.msg_irq, bus.cons_rvalid, bus.cons_rdata} !== {1'b1, 1'b1, pw[0][3]})
            $display("FAIL readack_data: got irq=%b v=%b data=%h want irq=1 v=1 data=%h", bus.msg_irq, bus.cons_rvalid, bus.cons_rdata, pw[0][3]);
        else n_pass++;
        clk_step();
        bus.cons_rd = 1'b0; bus.cons_ack = 1'b0; #1;
        n_checks++;
        if (bus.msg_irq !== 1'b0) $display("FAIL readack_release: got irq=%b want 0", bus.msg_irq);
        else n_pass++;
    endtask

    // Model: winner is the first requester after the previous owner; words land at sel 0..DEPTH-1 in order.
    task automatic test_random();
        int           exp_last, win, exp_beat, cyc, s;
        logic [N-1:0] mask, own;
        bit           found;
        logic         exp_v;
        logic [31:0]  exp_d;
        do_reset();
        exp_last = N - 1;
        for (int r = 0; r < 25; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            pact = '0; pgap = '0;
            for (int i = 0; i < N; i++) if (mask[i]) load_prod(i);
            found = 1'b0; win = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && mask[(exp_last + k) % N]) begin
                    found = 1'b1;
                    win = (exp_last + k) % N;
                end
            end
            own = '0; own[win] = 1'b1;
            exp_beat = 0; cyc = 0;
            while (!bus.msg_irq && cyc < 200) begin
                bus.mem_wr_ready = ($urandom_range(0, 3) != 0);
                pgap = (cyc == 0) ? '0 : N'($urandom);
                drive_prod(); #1;
                n_checks++;
                if ((bus.req_ready & ~own) !== '0) $display("FAIL rand_other_ready: got %b owner %0d", bus.req_ready, win);
                else n_pass++;
                if (bus.mem_wr) begin
                    n_checks++;
                    if (exp_beat >= DEPTH) $display("FAIL rand_extra_write: got sel=%0d want no write", bus.mem_wr_sel);
                    else if ({bus.mem_wr_sel, bus.mem_wdata} !== {3'(exp_beat), pw[win][exp_beat]})
                        $display("FAIL rand_write: got sel=%0d data=%h want sel=%0d data=%h",
                                 bus.mem_wr_sel, bus.mem_wdata, exp_beat, pw[win][exp_beat]);
                    else n_pass++;
                    exp_beat++;
                end
                clk_step();
                cyc++;
            end
            pgap = '0; bus.mem_wr_ready = 1'b1; drive_prod(); #1;
            n_checks++;
            if ({bus.msg_irq, bus.msg_src, 4'(exp_beat)} !== {1'b1, 3'(win), 4'(DEPTH)})
                $display("FAIL rand_post: got irq=%b src=%0d beats=%0d want irq=1 src=%0d beats=%0d",
                         bus.msg_irq, bus.msg_src, exp_beat, win, DEPTH);
            else n_pass++;
            for (int j = 0; j < 3; j++) begin
                s = $urandom_range(0, 7);
                bus.cons_rd = 1'b1; bus.cons_rd_sel = 3'(s);
                bus.cons_ack = (j == 2); #1;
                exp_v = (s < DEPTH);
                exp_d = exp_v ? pw[win][s % DEPTH] : 32'h0;
                n_checks++;
                if ({bus.cons_rvalid, bus.cons_rdata} !== {exp_v, exp_d})
                    $display("FAIL rand_read: sel=%0d got v=%b data=%h want v=%b data=%h", s, bus.cons_rvalid, bus.cons_rdata, exp_v, exp_d);
                else n_pass++;
            end
            clk_step();
            bus.cons_ack = 1'b0; bus.cons_rd = 1'b0;
            pact = '0; drive_prod(); #1;
            n_checks++;
            if (bus.msg_irq !== 1'b0) $display("FAIL rand_release: got irq=%b want 0", bus.msg_irq);
            else n_pass++;
            exp_last = win;
        end
    endtask

    initial begin
        reset = 1'b1;
        pact = '0; pgap = '0;
        for (int i = 0; i < N; i++) pidx[i] = 0;
        bus.req_valid = '0; bus.req_data = '0;
        bus.mem_wr_ready = 1'b1;
        bus.cons_rd = 1'b0; bus.cons_rd_sel = '0; bus.cons_ack = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_blocked();
        test_reset_mid();
        test_read_ack();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
